ext_tx_if: RTL and testbench

- AXI4 write-master front end of the MCHAN external unit; counterpart of the external read interface.
- Accepts write commands from the external command queue and issues AW bursts.
- Streams 64-bit data from the TX data buffer onto W with generated first/last-beat strobes.
- Consumes B responses to release transaction IDs and signal completion to the synchronisation unit.

---
 rtl/mchan_ext_pkg.sv | 18 +
 rtl/ext_tx_wdesc_fifo.sv | 65 ++++++
 rtl/ext_tx_if.sv | 230 +++++++++++++++++++++++
 tb/tb_ext_tx_if.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mchan_ext_pkg.sv
// Shared types and constants for the MCHAN external unit.
//
// wdesc_t describes one W burst: the number of beats minus one and the byte
// strobes for its first and last beat. The AXI constants are the encodings
// this unit drives on AW.
package mchan_ext_pkg;

    typedef struct packed {
        logic [7:0] nbeats_m1;
        logic [7:0] first_strb;
        logic [7:0] last_strb;
    } wdesc_t;

    localparam logic [2:0] AXI_SIZE_64 = 3'd3;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

endpackage

// File: rtl/ext_tx_wdesc_fifo.sv
// Descriptor FIFO between the AW issue side and the W streaming side.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset (flushes the FIFO)
//   push_i, data_i     write a descriptor; ignored while full_o is high
//   full_o             no free slot; a push is refused even if a pop happens
//                      in the same cycle
//   pop_i              drop the head descriptor; ignored while empty_o is high
//   data_o             head descriptor (meaningful only while empty_o is low)
//   empty_o            no descriptor stored
module ext_tx_wdesc_fifo
    import mchan_ext_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  wdesc_t data_i,
    output logic   full_o,
    input  logic   pop_i,
    output wdesc_t data_o,
    output logic   empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [PTR_W:0] wr_ptr_q;
    logic [PTR_W:0] rd_ptr_q;
    wdesc_t         mem [DEPTH];
    logic           push_ok;
    logic           pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    assign data_o = mem[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage is data only; validity is tracked entirely by the pointers.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/ext_tx_if.sv
// AXI4 write-master front end of the MCHAN external unit.
//
// Takes write commands from the external command queue, issues one AW burst
// per command, streams lane-aligned 64-bit data from the TX data buffer onto W
// with partial strobes on the first and last beat, and turns B responses into
// transaction-ID release / completion pulses.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   cmd_*_i / cmd_gnt_o        command (byte address, length-1, TID, INCR/FIXED)
//   valid_tid_i                a free TID exists; commands wait without one
//   release_tid_o, res_tid_o   one-cycle pulse per B beat with the ID to free
//   synch_req_o                one-cycle completion pulse per B beat
//   err_o                      one-cycle pulse for SLVERR/DECERR responses
//   tx_data_*                  write data source (req/gnt handshake)
//   axi_master_aw_* / w_* / b_* AXI4 write address, data and response channels
module ext_tx_if
    import mchan_ext_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int AXI_USER_WIDTH  = 6,
    parameter int AXI_ID_WIDTH    = 4,
    parameter int AXI_STRB_WIDTH  = AXI_DATA_WIDTH / 8,
    parameter int EXT_ADD_WIDTH   = 29,
    parameter int EXT_TID_WIDTH   = 4,
    parameter int MCHAN_LEN_WIDTH = 15,
    parameter int WDESC_DEPTH     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,

    input  logic [EXT_ADD_WIDTH-1:0]   cmd_add_i,
    input  logic [MCHAN_LEN_WIDTH-1:0] cmd_len_i,
    input  logic [EXT_TID_WIDTH-1:0]   cmd_tid_i,
    input  logic                       cmd_bst_i,
    input  logic                       cmd_req_i,
    output logic                       cmd_gnt_o,

    input  logic                       valid_tid_i,
    output logic                       release_tid_o,
    output logic [EXT_TID_WIDTH-1:0]   res_tid_o,
    output logic                       synch_req_o,
    output logic                       err_o,

    input  logic [AXI_DATA_WIDTH-1:0]  tx_data_dat_i,
    input  logic                       tx_data_req_i,
    output logic                       tx_data_gnt_o,

    output logic                       axi_master_aw_valid_o,
    output logic [AXI_ADDR_WIDTH-1:0]  axi_master_aw_addr_o,
    output logic [2:0]                 axi_master_aw_prot_o,
    output logic [3:0]                 axi_master_aw_region_o,
    output logic [7:0]                 axi_master_aw_len_o,
    output logic [2:0]                 axi_master_aw_size_o,
    output logic [1:0]                 axi_master_aw_burst_o,
    output logic                       axi_master_aw_lock_o,
    output logic [3:0]                 axi_master_aw_cache_o,
    output logic [3:0]                 axi_master_aw_qos_o,
    output logic [AXI_ID_WIDTH-1:0]    axi_master_aw_id_o,
    output logic [AXI_USER_WIDTH-1:0]  axi_master_aw_user_o,
    input  logic                       axi_master_aw_ready_i,

    output logic                       axi_master_w_valid_o,
    output logic [AXI_DATA_WIDTH-1:0]  axi_master_w_data_o,
    output logic [AXI_STRB_WIDTH-1:0]  axi_master_w_strb_o,
    output logic [AXI_USER_WIDTH-1:0]  axi_master_w_user_o,
    output logic                       axi_master_w_last_o,
    input  logic                       axi_master_w_ready_i,

    input  logic                       axi_master_b_valid_i,
    input  logic [1:0]                 axi_master_b_resp_i,
    input  logic [AXI_ID_WIDTH-1:0]    axi_master_b_id_i,
    input  logic [AXI_USER_WIDTH-1:0]  axi_master_b_user_i,
    output logic                       axi_master_b_ready_o
);

    function automatic logic [7:0] first_strb_f(input logic [2:0] offset);
        return 8'hFF << offset;
    endfunction

    // The last byte lane is the low 3 bits of (offset + length-1); keep every
    // lane up to and including it.
    function automatic logic [7:0] last_strb_f(input logic [2:0] offset,
                                               input logic [2:0] len_lo);
        logic [2:0] end_lane;
        end_lane = offset + len_lo;
        return 8'hFF >> (3'd7 - end_lane);
    endfunction

    logic                        cmd_accept;
    logic [MCHAN_LEN_WIDTH:0]    span;
    logic [7:0]                  nbeats_m1;
    wdesc_t                      desc_in;
    wdesc_t                      desc_head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        fifo_pop;

    logic                        aw_vld_p0;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr_p0;
    logic [7:0]                  aw_len_p0;
    logic [1:0]                  aw_burst_p0;
    logic [AXI_ID_WIDTH-1:0]     aw_id_p0;

    logic [7:0]                  beat_cnt;
    logic                        w_hs;
    logic                        w_last;
    logic [7:0]                  w_strb;

    logic                        b_ready_q;
    logic                        b_hs;
    logic                        unused_b_user;

    // Command acceptance only looks at the descriptor FIFO and the AW
    // register: the AW slot is free if empty or being handed off this cycle.
    assign cmd_accept = cmd_req_i & valid_tid_i & ~fifo_full &
                        (~aw_vld_p0 | axi_master_aw_ready_i);
    assign cmd_gnt_o  = cmd_accept;

    // Bytes spanned from the start of the first 8-byte word, minus one.
    assign span      = {1'b0, cmd_len_i} +
                       {{(MCHAN_LEN_WIDTH-2){1'b0}}, cmd_add_i[2:0]};
    assign nbeats_m1 = 8'(span >> 3);

    assign desc_in.nbeats_m1  = nbeats_m1;
    assign desc_in.first_strb = first_strb_f(cmd_add_i[2:0]);
    assign desc_in.last_strb  = last_strb_f(cmd_add_i[2:0], cmd_len_i[2:0]);

    ext_tx_wdesc_fifo #(
        .DEPTH (WDESC_DEPTH)
    ) i_wdesc_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (cmd_accept),
        .data_i  (desc_in),
        .full_o  (fifo_full),
        .pop_i   (fifo_pop),
        .data_o  (desc_head),
        .empty_o (fifo_empty)
    );

    // ---- stage p0: registered AW request ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_vld_p0   <= 1'b0;
            aw_addr_p0  <= '0;
            aw_len_p0   <= '0;
            aw_burst_p0 <= '0;
            aw_id_p0    <= '0;
        end else if (cmd_accept) begin
            aw_vld_p0   <= 1'b1;
            aw_addr_p0  <= AXI_ADDR_WIDTH'(cmd_add_i);
            aw_len_p0   <= nbeats_m1;
            aw_burst_p0 <= cmd_bst_i ? BURST_INCR : BURST_FIXED;
            aw_id_p0    <= AXI_ID_WIDTH'(cmd_tid_i);
        end else if (axi_master_aw_ready_i) begin
            aw_vld_p0   <= 1'b0;
        end
    end

    assign axi_master_aw_valid_o  = aw_vld_p0;
    assign axi_master_aw_addr_o   = aw_addr_p0;
    assign axi_master_aw_len_o    = aw_len_p0;
    assign axi_master_aw_size_o   = aw_vld_p0 ? AXI_SIZE_64 : 3'd0;
    assign axi_master_aw_burst_o  = aw_burst_p0;
    assign axi_master_aw_id_o     = aw_id_p0;
    assign axi_master_aw_prot_o   = '0;
    assign axi_master_aw_region_o = '0;
    assign axi_master_aw_lock_o   = 1'b0;
    assign axi_master_aw_cache_o  = '0;
    assign axi_master_aw_qos_o    = '0;
    assign axi_master_aw_user_o   = '0;

    // ---- W streaming: head descriptor drives strobes and last ----
    assign axi_master_w_valid_o = ~fifo_empty & tx_data_req_i;
    assign w_hs                 = axi_master_w_valid_o & axi_master_w_ready_i;
    assign tx_data_gnt_o        = w_hs;
    assign w_last               = (beat_cnt == desc_head.nbeats_m1);
    assign fifo_pop             = w_hs & w_last;

    // A single-beat burst takes both masks.
    always_comb begin
        w_strb = 8'hFF;
        if (beat_cnt == 8'd0) begin
            w_strb = w_strb & desc_head.first_strb;
        end
        if (w_last) begin
            w_strb = w_strb & desc_head.last_strb;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt <= 8'd0;
        end else if (w_hs) begin
            beat_cnt <= w_last ? 8'd0 : beat_cnt + 8'd1;
        end
    end

    assign axi_master_w_data_o = tx_data_dat_i;
    assign axi_master_w_strb_o = w_strb;
    assign axi_master_w_last_o = w_last;
    assign axi_master_w_user_o = '0;

    // ---- B response: always ready once out of reset ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            b_ready_q <= 1'b0;
        end else begin
            b_ready_q <= 1'b1;
        end
    end

    assign axi_master_b_ready_o = b_ready_q;
    assign b_hs                 = axi_master_b_valid_i & b_ready_q;
    assign release_tid_o        = b_hs;
    assign synch_req_o          = b_hs;
    assign err_o                = b_hs & axi_master_b_resp_i[1];
    assign res_tid_o            = EXT_TID_WIDTH'(axi_master_b_id_i);

    assign unused_b_user = ^axi_master_b_user_i;

    // Upstream keeps every command within a 256-beat AXI burst.
    a_burst_len_max : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        cmd_accept |-> ((span >> 3) <= (MCHAN_LEN_WIDTH+1)'(255))
    );

endmodule

// File: tb/tb_ext_tx_if.sv
module tb_ext_tx_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [28:0] cmd_add;
    logic [14:0] cmd_len;
    logic [3:0]  cmd_tid;
    logic        cmd_bst, cmd_req, cmd_gnt;
    logic        vtid, release_tid, synch_req, err;
    logic [3:0]  res_tid;
    logic [63:0] tdat;
    logic        treq, tgnt;
    logic        aw_valid, aw_lock, aw_ready;
    logic [31:0] aw_addr;
    logic [2:0]  aw_prot, aw_size;
    logic [3:0]  aw_region, aw_cache, aw_qos, aw_id;
    logic [7:0]  aw_len;
    logic [1:0]  aw_burst;
    logic [5:0]  aw_user, w_user, b_user;
    logic        w_valid, w_last, w_ready;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        b_valid, b_ready;
    logic [1:0]  b_resp;
    logic [3:0]  b_id;

    always #5 clk = ~clk;

    ext_tx_if dut (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_add_i(cmd_add), .cmd_len_i(cmd_len), .cmd_tid_i(cmd_tid),
        .cmd_bst_i(cmd_bst), .cmd_req_i(cmd_req), .cmd_gnt_o(cmd_gnt),
        .valid_tid_i(vtid), .release_tid_o(release_tid), .res_tid_o(res_tid),
        .synch_req_o(synch_req), .err_o(err),
        .tx_data_dat_i(tdat), .tx_data_req_i(treq), .tx_data_gnt_o(tgnt),
        .axi_master_aw_valid_o(aw_valid), .axi_master_aw_addr_o(aw_addr),
        .axi_master_aw_prot_o(aw_prot), .axi_master_aw_region_o(aw_region),
        .axi_master_aw_len_o(aw_len), .axi_master_aw_size_o(aw_size),
        .axi_master_aw_burst_o(aw_burst), .axi_master_aw_lock_o(aw_lock),
        .axi_master_aw_cache_o(aw_cache), .axi_master_aw_qos_o(aw_qos),
        .axi_master_aw_id_o(aw_id), .axi_master_aw_user_o(aw_user),
        .axi_master_aw_ready_i(aw_ready),
        .axi_master_w_valid_o(w_valid), .axi_master_w_data_o(w_data),
        .axi_master_w_strb_o(w_strb), .axi_master_w_user_o(w_user),
        .axi_master_w_last_o(w_last), .axi_master_w_ready_i(w_ready),
        .axi_master_b_valid_i(b_valid), .axi_master_b_resp_i(b_resp),
        .axi_master_b_id_i(b_id), .axi_master_b_user_i(b_user),
        .axi_master_b_ready_o(b_ready)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: expected AW requests, expected W beats (derived byte by
    // byte from the command's address range) and number of bursts whose last
    // W beat has not yet been sent.
    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  burst;
        logic [3:0]  id;
    } aw_exp_t;
    typedef struct {
        logic [7:0] strb;
        logic       last;
    } beat_t;

    aw_exp_t aw_q[$];
    beat_t   beat_q[$];
    int      desc_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_push(input logic [28:0] add, input logic [14:0] len,
                              input logic bst, input logic [3:0] tid);
        longint  lo, hi, first_w, last_w;
        aw_exp_t a;
        lo      = longint'(add);
        hi      = lo + longint'(len);
        first_w = lo / 8;
        last_w  = hi / 8;
        a.addr  = {3'b000, add};
        a.len   = 8'(last_w - first_w);
        a.burst = {1'b0, bst};
        a.id    = tid;
        aw_q.push_back(a);
        for (longint w = first_w; w <= last_w; w++) begin
            beat_t b;
            b.strb = 8'h00;
            for (int k = 0; k < 8; k++) begin
                if ((w * 8 + k) >= lo && (w * 8 + k) <= hi) b.strb[k] = 1'b1;
            end
            b.last = (w == last_w);
            beat_q.push_back(b);
        end
        desc_cnt++;
    endtask

    task automatic model_flush();
        aw_q.delete();
        beat_q.delete();
        desc_cnt = 0;
    endtask

    // Called once per cycle after the inputs are driven: checks every output
    // against the model, then advances the model by this cycle's handshakes.
    task automatic settle();
        logic exp_gnt, exp_awv, exp_wv;
        #1;
        exp_gnt = cmd_req && vtid && (desc_cnt < 4) && (aw_q.size() == 0 || aw_ready);
        exp_awv = (aw_q.size() != 0);
        exp_wv  = (desc_cnt > 0) && treq;
        chk("cmd_gnt", cmd_gnt, exp_gnt);
        chk("aw_valid", aw_valid, exp_awv);
        if (exp_awv) begin
            chk("aw_addr", aw_addr, aw_q[0].addr);
            chk("aw_len", aw_len, aw_q[0].len);
            chk("aw_burst", aw_burst, aw_q[0].burst);
            chk("aw_id", aw_id, aw_q[0].id);
            chk("aw_size", aw_size, 3'd3);
        end
        chk("aw_misc_zero", {aw_prot, aw_region, aw_lock, aw_cache, aw_qos, aw_user, w_user}, 0);
        chk("w_valid", w_valid, exp_wv);
        chk("tx_gnt", tgnt, exp_wv && w_ready);
        if (exp_wv && beat_q.size() > 0) begin
            chk("w_strb", w_strb, beat_q[0].strb);
            chk("w_last", w_last, beat_q[0].last);
            if (w_ready) begin
                chk("w_data", w_data, tdat);
                if (beat_q[0].last) desc_cnt--;
                void'(beat_q.pop_front());
            end
        end
        chk("b_ready", b_ready, 1'b1);
        chk("release_tid", release_tid, b_valid);
        chk("synch_req", synch_req, b_valid);
        chk("err", err, b_valid && b_resp[1]);
        if (b_valid) chk("res_tid", res_tid, b_id);
        if (exp_awv && aw_ready) void'(aw_q.pop_front());
        if (exp_gnt) model_push(cmd_add, cmd_len, cmd_bst, cmd_tid);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            settle();
            advance();
        end
    endtask

    task automatic set_cmd(input logic [28:0] add, input logic [14:0] len,
                           input logic bst, input logic [3:0] tid);
        cmd_add = add; cmd_len = len; cmd_bst = bst; cmd_tid = tid; cmd_req = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_add = '0; cmd_len = '0; cmd_tid = '0; cmd_bst = 1'b0; cmd_req = 1'b0;
        vtid = 1'b1; tdat = '0; treq = 1'b0; aw_ready = 1'b0; w_ready = 1'b0;
        b_valid = 1'b0; b_resp = '0; b_id = '0; b_user = '0;

        // Reset state, with data and a B beat offered.
        repeat (3) @(posedge clk);
        #1;
        treq = 1'b1; b_valid = 1'b1; b_id = 4'd5;
        #1;
        chk("rst_aw_valid", aw_valid, 1'b0);
        chk("rst_aw_fields", {aw_addr, aw_len, aw_size, aw_burst, aw_id}, 0);
        chk("rst_w_valid", w_valid, 1'b0);
        chk("rst_tx_gnt", tgnt, 1'b0);
        chk("rst_b_ready", b_ready, 1'b0);
        chk("rst_release", release_tid, 1'b0);
        chk("rst_synch", synch_req, 1'b0);
        chk("rst_err", err, 1'b0);
        rst_n = 1'b1; treq = 1'b0; b_valid = 1'b0;
        advance();

        // Aligned 64-byte INCR burst, then its B response.
        set_cmd(29'h100, 15'd63, 1'b1, 4'd3);
        settle();
        chk("t1_gnt", cmd_gnt, 1'b1);
        advance();
        cmd_req = 1'b0; aw_ready = 1'b1;
        settle();
        chk("t1_aw_len", aw_len, 8'd7);
        chk("t1_aw_burst", aw_burst, 2'b01);
        advance();
        aw_ready = 1'b0; w_ready = 1'b1; treq = 1'b1;
        repeat (8) begin
            tdat = {$urandom(), $urandom()};
            settle();
            advance();
        end
        settle();
        chk("t1_w_idle", w_valid, 1'b0);
        advance();
        b_valid = 1'b1; b_id = 4'd3; b_resp = 2'b00;
        settle();
        chk("t1_release", release_tid, 1'b1);
        chk("t1_res_tid", res_tid, 4'd3);
        chk("t1_synch", synch_req, 1'b1);
        advance();
        b_valid = 1'b0;
        run(1);

        // Unaligned two-beat burst 0x105..0x10E.
        set_cmd(29'h105, 15'd9, 1'b1, 4'd4);
        run(1);
        cmd_req = 1'b0; aw_ready = 1'b1;
        tdat = 64'h1122334455667788;
        settle();
        chk("t2_aw_len", aw_len, 8'd1);
        chk("t2_strb0", w_strb, 8'hE0);
        chk("t2_last0", w_last, 1'b0);
        advance();
        settle();
        chk("t2_strb1", w_strb, 8'h7F);
        chk("t2_last1", w_last, 1'b1);
        advance();

        // Single-beat burst inside one word.
        set_cmd(29'h202, 15'd3, 1'b0, 4'd5);
        run(1);
        cmd_req = 1'b0;
        settle();
        chk("t3_aw_len", aw_len, 8'd0);
        chk("t3_aw_burst", aw_burst, 2'b00);
        chk("t3_strb", w_strb, 8'h3C);
        chk("t3_last", w_last, 1'b1);
        advance();
        aw_ready = 1'b0;

        // AW stalled for five cycles: payload held, next command blocked,
        // W of the stalled burst still streams.
        set_cmd(29'h300, 15'd15, 1'b1, 4'd1);
        run(1);
        set_cmd(29'h400, 15'd7, 1'b1, 4'd2);
        for (int i = 0; i < 5; i++) begin
            tdat = {$urandom(), $urandom()};
            settle();
            chk("t4_gnt_blocked", cmd_gnt, 1'b0);
            chk("t4_aw_hold_valid", aw_valid, 1'b1);
            chk("t4_aw_hold_addr", aw_addr, 32'h300);
            chk("t4_aw_hold_len", aw_len, 8'd1);
            advance();
        end
        aw_ready = 1'b1;
        settle();
        chk("t4_gnt_b2b", cmd_gnt, 1'b1);
        advance();
        cmd_req = 1'b0;
        run(3);

        // Fill the descriptor FIFO with W stalled.
        w_ready = 1'b0; treq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_cmd(29'h500 + 29'(i * 8), 15'd7, 1'b1, 4'(i));
            settle();
            chk("t5_fill_gnt", cmd_gnt, 1'b1);
            advance();
        end
        set_cmd(29'h540, 15'd7, 1'b1, 4'd9);
        settle();
        chk("t5_full_gnt", cmd_gnt, 1'b0);
        advance();
        w_ready = 1'b1;
        settle();
        chk("t5_full_pop_gnt", cmd_gnt, 1'b0);
        chk("t5_pop_last", w_last, 1'b1);
        advance();
        w_ready = 1'b0;
        settle();
        chk("t5_after_pop_gnt", cmd_gnt, 1'b1);
        advance();
        cmd_req = 1'b0; w_ready = 1'b1;
        run(6);

        // Error response.
        b_valid = 1'b1; b_id = 4'd9; b_resp = 2'b10;
        settle();
        chk("t6_err", err, 1'b1);
        chk("t6_release", release_tid, 1'b1);
        chk("t6_res_tid", res_tid, 4'd9);
        advance();
        b_valid = 1'b0; b_resp = 2'b00;
        settle();
        chk("t6_err_clear", err, 1'b0);
        advance();

        // Reset in the middle of a burst with AW still pending.
        aw_ready = 1'b0;
        set_cmd(29'h600, 15'd63, 1'b1, 4'd7);
        run(1);
        cmd_req = 1'b0;
        run(3);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_aw_valid", aw_valid, 1'b0);
        chk("t7_rst_w_valid", w_valid, 1'b0);
        chk("t7_rst_tx_gnt", tgnt, 1'b0);
        chk("t7_rst_b_ready", b_ready, 1'b0);
        model_flush();
        rst_n = 1'b1;
        advance();
        settle();
        chk("t7_fifo_empty", w_valid, 1'b0);
        advance();

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            cmd_req  = ($urandom_range(0, 1) == 1);
            cmd_add  = 29'($urandom());
            cmd_len  = 15'($urandom_range(0, 300));
            cmd_bst  = 1'($urandom_range(0, 1));
            cmd_tid  = 4'($urandom_range(0, 15));
            vtid     = ($urandom_range(0, 4) != 0);
            aw_ready = ($urandom_range(0, 4) < 3);
            w_ready  = ($urandom_range(0, 4) < 3);
            treq     = ($urandom_range(0, 9) < 7);
            tdat     = {$urandom(), $urandom()};
            b_valid  = ($urandom_range(0, 4) == 0);
            b_id     = 4'($urandom_range(0, 15));
            b_resp   = 2'($urandom_range(0, 3));
            b_user   = 6'($urandom_range(0, 63));
            settle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
